// File: rtl/matrix_calculation.sv
// Systolic Smith-Waterman scoring core: NUM_PU blocks of NUM_ROWS_PE x NUM_COLS_PE cells,
// boundary muxes fed from registered neighbour results, registered scores and traceback codes.
package design_variables;
  localparam int SEQ_LENGTH       = 32;
  localparam int LETTER_WIDTH     = 2;
  localparam int NUM_PU           = 16;
  localparam int NUM_ROWS_PE      = 2;
  localparam int NUM_COLS_PE      = 2;
  localparam int SCORE_WIDTH      = 8;
  localparam int DATA_PACKET_SIZE = 2;
  localparam int MATCH            = 2;
  localparam int MISMATCH         = 1;
  localparam int GAP              = 1;
endpackage

module matrix_calculation
  import design_variables::*;
(
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic [SEQ_LENGTH*LETTER_WIDTH-1:0]                          query_seq,
  input  logic [SEQ_LENGTH*LETTER_WIDTH-1:0]                          database_seq,
  input  logic [(NUM_PU-1)*2-1:0]                                     top_sel,
  input  logic [(NUM_PU-1)*2-1:0]                                     left_sel,
  input  logic [(NUM_PU-1)*2-1:0]                                     diagonal_sel,
  input  logic [4:0]                                                  global_counter,
  input  logic [NUM_PU*NUM_ROWS_PE*5-1:0]                             query_letter_sel,
  input  logic [NUM_PU*NUM_COLS_PE*5-1:0]                             database_letter_sel,
  output logic [NUM_PU*NUM_ROWS_PE*NUM_COLS_PE*SCORE_WIDTH-1:0]       scores_out,
  output logic [NUM_PU*NUM_ROWS_PE*NUM_COLS_PE*DATA_PACKET_SIZE-1:0]  data_packet
);
  localparam int IDX_W = 5;
  localparam int EXT_W = SCORE_WIDTH + 2;

  typedef logic [SCORE_WIDTH-1:0]      score_t;
  typedef logic [DATA_PACKET_SIZE-1:0] dir_t;
  typedef logic signed [EXT_W-1:0]     ext_t;

  localparam ext_t MATCH_E    = ext_t'(MATCH);
  localparam ext_t MISMATCH_E = ext_t'(MISMATCH);
  localparam ext_t GAP_E      = ext_t'(GAP);

  localparam dir_t DIR_STOP = dir_t'(0);
  localparam dir_t DIR_DIAG = dir_t'(1);
  localparam dir_t DIR_TOP  = dir_t'(2);
  localparam dir_t DIR_LEFT = dir_t'(3);

  // Ties resolve diagonal > top > left; a zero score is always a stop.
  function automatic logic [DATA_PACKET_SIZE+SCORE_WIDTH-1:0] cell_eval(
    input score_t t,
    input score_t l,
    input score_t d,
    input logic   eq
  );
    ext_t de;
    ext_t te;
    ext_t le;
    ext_t h;
    dir_t code;
    de = $signed({2'b00, d}) + (eq ? MATCH_E : -MISMATCH_E);
    te = $signed({2'b00, t}) - GAP_E;
    le = $signed({2'b00, l}) - GAP_E;
    h  = '0;
    if (de > h) h = de;
    if (te > h) h = te;
    if (le > h) h = le;
    if (h == '0)      code = DIR_STOP;
    else if (h == de) code = DIR_DIAG;
    else if (h == te) code = DIR_TOP;
    else              code = DIR_LEFT;
    return {code, h[SCORE_WIDTH-1:0]};
  endfunction

  score_t h_q      [NUM_PU][NUM_ROWS_PE][NUM_COLS_PE];
  score_t h_d      [NUM_PU][NUM_ROWS_PE][NUM_COLS_PE];
  dir_t   dir_q    [NUM_PU][NUM_ROWS_PE][NUM_COLS_PE];
  dir_t   dir_d    [NUM_PU][NUM_ROWS_PE][NUM_COLS_PE];
  score_t br_dly_q [NUM_PU];
  logic   step_en;

  assign step_en = (global_counter != '0);

  for (genvar p = 0; p < NUM_PU; p++) begin : g_pu
    logic [1:0] tsel;
    logic [1:0] lsel;
    logic [1:0] dsel;
    score_t     up_bot    [NUM_COLS_PE];
    score_t     dn_bot    [NUM_COLS_PE];
    score_t     up_rc     [NUM_ROWS_PE];
    score_t     dn_rc     [NUM_ROWS_PE];
    score_t     up_br;
    score_t     up_br_dly;
    score_t     top_v     [NUM_COLS_PE];
    score_t     left_v    [NUM_ROWS_PE];
    score_t     diag_v;

    // The last PU always follows the wavefront from its upper neighbour.
    if (p == NUM_PU-1) begin : g_hard
      assign tsel = 2'd1;
      assign lsel = 2'd1;
      assign dsel = 2'd1;
    end else begin : g_sel
      assign tsel = top_sel[2*p +: 2];
      assign lsel = left_sel[2*p +: 2];
      assign dsel = diagonal_sel[2*p +: 2];
    end

    if (p == 0) begin : g_no_up
      always_comb begin
        up_br     = '0;
        up_br_dly = '0;
        for (int c = 0; c < NUM_COLS_PE; c++) up_bot[c] = '0;
        for (int r = 0; r < NUM_ROWS_PE; r++) up_rc[r] = '0;
      end
    end else begin : g_up
      always_comb begin
        up_br     = h_q[p-1][NUM_ROWS_PE-1][NUM_COLS_PE-1];
        up_br_dly = br_dly_q[p-1];
        for (int c = 0; c < NUM_COLS_PE; c++) up_bot[c] = h_q[p-1][NUM_ROWS_PE-1][c];
        for (int r = 0; r < NUM_ROWS_PE; r++) up_rc[r] = h_q[p-1][r][NUM_COLS_PE-1];
      end
    end

    if (p == NUM_PU-1) begin : g_no_dn
      always_comb begin
        for (int c = 0; c < NUM_COLS_PE; c++) dn_bot[c] = '0;
        for (int r = 0; r < NUM_ROWS_PE; r++) dn_rc[r] = '0;
      end
    end else begin : g_dn
      always_comb begin
        for (int c = 0; c < NUM_COLS_PE; c++) dn_bot[c] = h_q[p+1][NUM_ROWS_PE-1][c];
        for (int r = 0; r < NUM_ROWS_PE; r++) dn_rc[r] = h_q[p+1][r][NUM_COLS_PE-1];
      end
    end

    always_comb begin
      for (int c = 0; c < NUM_COLS_PE; c++) begin
        case (tsel)
          2'd0:    top_v[c] = '0;
          2'd1:    top_v[c] = up_bot[c];
          2'd2:    top_v[c] = h_q[p][NUM_ROWS_PE-1][c];
          default: top_v[c] = dn_bot[c];
        endcase
      end
      for (int r = 0; r < NUM_ROWS_PE; r++) begin
        case (lsel)
          2'd0:    left_v[r] = '0;
          2'd1:    left_v[r] = h_q[p][r][NUM_COLS_PE-1];
          2'd2:    left_v[r] = up_rc[r];
          default: left_v[r] = dn_rc[r];
        endcase
      end
      case (dsel)
        2'd0:    diag_v = '0;
        2'd1:    diag_v = up_br_dly;
        2'd2:    diag_v = up_br;
        default: diag_v = h_q[p][NUM_ROWS_PE-1][NUM_COLS_PE-1];
      endcase
    end

    for (genvar r = 0; r < NUM_ROWS_PE; r++) begin : g_r
      for (genvar c = 0; c < NUM_COLS_PE; c++) begin : g_c
        score_t           t_v;
        score_t           l_v;
        score_t           d_v;
        score_t           h_v;
        dir_t             dir_v;
        logic [IDX_W-1:0] q_idx;
        logic [IDX_W-1:0] d_idx;
        logic             eq;

        if (r == 0) begin : g_t_edge
          assign t_v = top_v[c];
        end else begin : g_t_in
          assign t_v = g_r[r-1].g_c[c].h_v;
        end

        if (c == 0) begin : g_l_edge
          assign l_v = left_v[r];
        end else begin : g_l_in
          assign l_v = g_r[r].g_c[c-1].h_v;
        end

        // Edge cells take their corner from the boundary vectors, (0,0) from the diag mux.
        if (r == 0 && c == 0) begin : g_d_corner
          assign d_v = diag_v;
        end else if (r == 0) begin : g_d_top
          assign d_v = top_v[c-1];
        end else if (c == 0) begin : g_d_left
          assign d_v = left_v[r-1];
        end else begin : g_d_in
          assign d_v = g_r[r-1].g_c[c-1].h_v;
        end

        assign q_idx = query_letter_sel[(p*NUM_ROWS_PE + r)*IDX_W +: IDX_W];
        assign d_idx = database_letter_sel[(p*NUM_COLS_PE + c)*IDX_W +: IDX_W];
        assign eq    = (query_seq[q_idx*LETTER_WIDTH +: LETTER_WIDTH] ==
                        database_seq[d_idx*LETTER_WIDTH +: LETTER_WIDTH]);

        assign {dir_v, h_v}   = cell_eval(t_v, l_v, d_v, eq);
        assign h_d[p][r][c]   = h_v;
        assign dir_d[p][r][c] = dir_v;

        assign scores_out[((p*NUM_ROWS_PE + r)*NUM_COLS_PE + c)*SCORE_WIDTH +: SCORE_WIDTH] =
          h_q[p][r][c];
        assign data_packet[((p*NUM_ROWS_PE + r)*NUM_COLS_PE + c)*DATA_PACKET_SIZE +: DATA_PACKET_SIZE] =
          dir_q[p][r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PU; p++) begin
        br_dly_q[p] <= '0;
        for (int r = 0; r < NUM_ROWS_PE; r++) begin
          for (int c = 0; c < NUM_COLS_PE; c++) begin
            h_q[p][r][c]   <= '0;
            dir_q[p][r][c] <= '0;
          end
        end
      end
    end else if (step_en) begin
      for (int p = 0; p < NUM_PU; p++) begin
        br_dly_q[p] <= h_q[p][NUM_ROWS_PE-1][NUM_COLS_PE-1];
        for (int r = 0; r < NUM_ROWS_PE; r++) begin
          for (int c = 0; c < NUM_COLS_PE; c++) begin
            h_q[p][r][c]   <= h_d[p][r][c];
            dir_q[p][r][c] <= dir_d[p][r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_calculation.sv
// Scoreboard bench for matrix_calculation: directed steps push expected scores/codes,
// monitors compare on the sampling edge and right after an asynchronous reset.
module tb_matrix_calculation;
  localparam int NPU = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  q_seq;
  logic [63:0]  d_seq;
  logic [29:0]  t_sel;
  logic [29:0]  l_sel;
  logic [29:0]  g_sel;
  logic [4:0]   gcnt;
  logic [159:0] q_ls;
  logic [159:0] d_ls;
  logic [511:0] scores;
  logic [127:0] pkts;

  matrix_calculation dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .query_seq           (q_seq),
    .database_seq        (d_seq),
    .top_sel             (t_sel),
    .left_sel            (l_sel),
    .diagonal_sel        (g_sel),
    .global_counter      (gcnt),
    .query_letter_sel    (q_ls),
    .database_letter_sel (d_ls),
    .scores_out          (scores),
    .data_packet         (pkts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    int           when;
    logic [511:0] s_exp;
    logic [511:0] s_msk;
    logic [127:0] p_exp;
    logic [127:0] p_msk;
  } exp_t;

  exp_t sq[$];
  exp_t aq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [511:0] st_s, st_sm;
  logic [127:0] st_p, st_pm;

  task automatic check(input exp_t e);
    n_vec++;
    if ((((scores ^ e.s_exp) & e.s_msk) !== '0) || (((pkts ^ e.p_exp) & e.p_msk) !== '0)) begin
      n_bad++;
      $display("FAIL %s: got scores=%h pkts=%h, want scores=%h pkts=%h",
               e.name, scores & e.s_msk, pkts & e.p_msk, e.s_exp, e.p_exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].when <= cyc) check(sq.pop_front());
    end
  end

  initial begin
    forever begin
      @(negedge rst_n);
      #1;
      if (aq.size() > 0) check(aq.pop_front());
    end
  end

  task automatic stage_clear();
    st_s = '0; st_sm = '0; st_p = '0; st_pm = '0;
  endtask

  task automatic stage_all_zero();
    st_s = '0; st_sm = '1; st_p = '0; st_pm = '1;
  endtask

  task automatic put_cell(input int p, input int r, input int c, input int s, input int k);
    int i;
    i = (p*2 + r)*2 + c;
    st_s[i*8 +: 8]  = 8'(s);
    st_sm[i*8 +: 8] = 8'hFF;
    st_p[i*2 +: 2]  = 2'(k);
    st_pm[i*2 +: 2] = 2'b11;
  endtask

  task automatic put_pu(input int p, input int s00, input int s01, input int s10, input int s11,
                        input int k00, input int k01, input int k10, input int k11);
    put_cell(p, 0, 0, s00, k00);
    put_cell(p, 0, 1, s01, k01);
    put_cell(p, 1, 0, s10, k10);
    put_cell(p, 1, 1, s11, k11);
  endtask

  task automatic push(input string nm, input bit async_chk);
    exp_t e;
    e.name  = nm;
    e.when  = cyc + 1;
    e.s_exp = st_s; e.s_msk = st_sm; e.p_exp = st_p; e.p_msk = st_pm;
    if (async_chk) aq.push_back(e);
    else           sq.push_back(e);
    stage_clear();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    q_seq = '0; d_seq = '0; t_sel = '0; l_sel = '0; g_sel = '0;
    q_ls = '0; d_ls = '0; gcnt = '0;
  endtask

  task automatic rand_inputs();
    q_seq = {$urandom, $urandom};
    d_seq = {$urandom, $urandom};
    t_sel = 30'($urandom);
    l_sel = 30'($urandom);
    g_sel = 30'($urandom);
    q_ls  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d_ls  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    gcnt  = 5'($urandom_range(31, 1));
  endtask

  task automatic set_pu(input int p, input int q0, input int q1, input int d0, input int d1,
                        input logic [1:0] t, input logic [1:0] l, input logic [1:0] g);
    q_ls[(p*2)*5 +: 5]   = 5'(q0);
    q_ls[(p*2+1)*5 +: 5] = 5'(q1);
    d_ls[(p*2)*5 +: 5]   = 5'(d0);
    d_ls[(p*2+1)*5 +: 5] = 5'(d1);
    if (p < NPU-1) begin
      t_sel[p*2 +: 2] = t;
      l_sel[p*2 +: 2] = l;
      g_sel[p*2 +: 2] = g;
    end
  endtask

  // PU p owns block row p; block (p, k-1-p) is on the wavefront at step k.
  task automatic sweep_step(input int k);
    int j;
    for (int p = 0; p < NPU; p++) begin
      j = k - 1 - p;
      if (j >= 0 && j < NPU)
        set_pu(p, 2*p, 2*p+1, 2*j, 2*j+1, (p == 0) ? 2'd0 : 2'd1, (j == 0) ? 2'd0 : 2'd1,
               (p == 0 || j == 0) ? 2'd0 : 2'd1);
      else
        set_pu(p, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0);
    end
    gcnt = 5'(k);
  endtask

  task automatic stage_sweep_step1();
    stage_all_zero();
    put_pu(0, 2, 1, 1, 4, 1, 3, 2, 1);
  endtask

  initial begin
    clear_inputs();
    stage_clear();
    rand_inputs();

    repeat (3) begin
      tick(); rand_inputs();
      stage_all_zero(); push("rst_hold", 1'b0);
    end
    repeat (2) begin
      tick(); rand_inputs(); rst_n = 1'b1; gcnt = '0;
      stage_all_zero(); push("idle_hold", 1'b0);
    end

    tick(); clear_inputs(); gcnt = 5'd1;
    put_pu(0, 2, 2, 2, 4, 1, 1, 1, 1); push("all_match", 1'b0);

    tick(); d_seq = '1; gcnt = 5'd2;
    for (int p = 0; p < NPU-1; p++) put_pu(p, 0, 0, 0, 0, 0, 0, 0, 0);
    push("all_mismatch", 1'b0);

    tick(); d_seq = '0; gcnt = 5'd3;
    put_pu(0, 2, 2, 2, 4, 1, 1, 1, 1); push("step1_match", 1'b0);

    tick(); d_seq = '1; l_sel[1:0] = 2'd1; gcnt = 5'd4;
    put_pu(0, 1, 0, 3, 2, 3, 0, 3, 3); push("step2_left_own", 1'b0);

    repeat (2) begin
      tick(); rand_inputs(); gcnt = '0;
      put_pu(0, 1, 0, 3, 2, 3, 0, 3, 3); push("gc0_hold", 1'b0);
    end

    tick(); reset_pulse();
    clear_inputs();
    q_seq = 64'hE4E4_E4E4_E4E4_E4E4;
    d_seq = 64'hE4E4_E4E4_E4E4_E4E4;
    for (int k = 1; k <= 31; k++) begin
      tick(); sweep_step(k);
      if (k == 1) begin
        stage_sweep_step1(); push("sweep_step1", 1'b0);
      end
      if (k == 31) begin
        put_cell(15, 1, 1, 64, 1); push("sweep_final", 1'b0);
      end
    end
    tick(); gcnt = '0;

    tick(); reset_pulse();
    for (int k = 1; k <= 3; k++) begin
      tick(); sweep_step(k);
    end
    tick(); gcnt = '0;
    stage_all_zero(); push("async_reset", 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    tick(); rst_n = 1'b1;

    tick(); sweep_step(1);
    stage_sweep_step1(); push("restart_step1", 1'b0);
    tick(); gcnt = '0;

    repeat (3) tick();
    while (sq.size() > 0) begin
      void'(sq.pop_front());
      n_vec++; n_bad++;
      $display("FAIL unchecked: got no sample, want one");
    end
    while (aq.size() > 0) begin
      void'(aq.pop_front());
      n_vec++; n_bad++;
      $display("FAIL unchecked_async: got no sample, want one");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
